// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite downstream port among NUM requesters.
// Write and read channels are independent instances of the same channel arbiter.

package axi_lite_rr_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;
endpackage

// Per-channel arbiter.
// Handshake contract: a_hs is the downstream address valid&&ready pulse and
// d_hs is the downstream response valid&&ready pulse. Each is honoured only
// in the one state that waits for it: a_hs in ADDR and d_hs in RESP.
module axi_lite_rr_chan
    import axi_lite_rr_arbiter_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int NSIZE   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [NUM-1:0]   req,
    input  logic [NUM-1:0]   lock,
    input  logic             a_hs,
    input  logic             d_hs,
    output logic [NUM-1:0]   grant,
    output logic [NSIZE-1:0] addr,
    output logic             timeout,
    output arb_state_e       state
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NSIZE-1:0] LAST_IDX = NSIZE'(NUM - 1);

    arb_state_e       state_q, state_d;
    logic [NUM-1:0]   grant_q, grant_d;
    logic [NSIZE-1:0] addr_q, addr_d;
    logic [NSIZE-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [NSIZE-1:0] win;
    logic [NSIZE-1:0] cand;
    logic [NSIZE-1:0] next_ptr;
    int               idx;

    // First requester at or above the pointer, wrapping past NUM-1 to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM) idx = idx - NUM;
            cand = NSIZE'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign next_ptr = (addr_q == LAST_IDX) ? '0 : addr_q + NSIZE'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d      = ST_ADDR;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    addr_d       = win;
                end
            end
            ST_ADDR: begin
                if (a_hs) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end
            end
            ST_RESP: begin
                if (d_hs) begin
                    if (lock[addr_q]) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = next_ptr;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    // Abandon the transaction; any lock is dropped with it.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (req[addr_q]) begin
                    state_d = ST_ADDR;
                end else if (!lock[addr_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign addr    = addr_q;
    assign timeout = timeout_q;
    assign state   = state_q;
endmodule

module axi_lite_rr_arbiter
    import axi_lite_rr_arbiter_pkg::*;
#(
    parameter int  NUM     = 4,
    parameter int  TIMEOUT = 1023,
    localparam int NSIZE   = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [NUM-1:0]   aw_req,
    input  logic [NUM-1:0]   aw_lock,
    input  logic             aw_hs,
    input  logic             b_hs,
    input  logic [NUM-1:0]   ar_req,
    input  logic [NUM-1:0]   ar_lock,
    input  logic             ar_hs,
    input  logic             r_hs,
    output logic [NUM-1:0]   wgrant,
    output logic [NSIZE-1:0] waddr,
    output logic             wbusy,
    output logic             wtimeout,
    output logic [NUM-1:0]   rgrant,
    output logic [NSIZE-1:0] raddr,
    output logic             rbusy,
    output logic             rtimeout
);
    arb_state_e w_state;
    arb_state_e r_state;

    axi_lite_rr_chan #(.NUM(NUM), .NSIZE(NSIZE), .TIMEOUT(TIMEOUT)) u_wr (
        .clock   (clock),
        .rst_n   (rst_n),
        .req     (aw_req),
        .lock    (aw_lock),
        .a_hs    (aw_hs),
        .d_hs    (b_hs),
        .grant   (wgrant),
        .addr    (waddr),
        .timeout (wtimeout),
        .state   (w_state)
    );

    axi_lite_rr_chan #(.NUM(NUM), .NSIZE(NSIZE), .TIMEOUT(TIMEOUT)) u_rd (
        .clock   (clock),
        .rst_n   (rst_n),
        .req     (ar_req),
        .lock    (ar_lock),
        .a_hs    (ar_hs),
        .d_hs    (r_hs),
        .grant   (rgrant),
        .addr    (raddr),
        .timeout (rtimeout),
        .state   (r_state)
    );

    // Busy is decoded from the state register, so it stays a registered output.
    assign wbusy = (w_state != ST_IDLE);
    assign rbusy = (r_state != ST_IDLE);
endmodule

// File: doc/axi_lite_rr_arbiter.md
AXI_LITE_RR_ARBITER -- requirements
Module: axi_lite_rr_arbiter

Interface
REQ-001 Parameter NUM, default 4: number of AXI-Lite requesters sharing one downstream port (2..16).
REQ-002 Parameter NSIZE, derived: 1 if NUM<=2, 2 if <=4, 3 if <=8, else 4; width of index outputs.
REQ-003 Parameter TIMEOUT, default 1023: max cycles waiting for a response; 0 disables the timeout.
REQ-004 Ports (name direction width meaning), one clock, asynchronous active-low reset:
clock     in   1      single clock, all logic rising-edge
rst_n     in   1      asynchronous active-low reset
aw_req    in   NUM    per-requester axi_awvalid
aw_lock   in   NUM    per-requester axi_awlock
aw_hs     in   1      downstream axi_awvalid && axi_awready
b_hs      in   1      downstream axi_bvalid && axi_bready
ar_req    in   NUM    per-requester axi_arvalid
ar_lock   in   NUM    per-requester axi_arlock
ar_hs     in   1      downstream axi_arvalid && axi_arready
r_hs      in   1      downstream axi_rvalid && axi_rready
wgrant    out  NUM    one-hot write grant
waddr     out  NSIZE  write select index for the datapath mux
wbusy     out  1      write channel not IDLE
wtimeout  out  1      one-cycle pulse, write response timeout
rgrant    out  NUM    one-hot read grant
raddr     out  NSIZE  read select index
rbusy     out  1      read channel not IDLE
rtimeout  out  1      one-cycle pulse, read response timeout

Function
REQ-005 Write and read channels shall be two independent, identical arbiters; below uses write names, read maps aw->ar, b->r, w->r.
REQ-006 FSM states: IDLE, ADDR, RESP, HOLD; wbusy = (state != IDLE).
REQ-007 IDLE: if |aw_req, winner = first set bit searching from rr pointer upward with wrap; next cycle state=ADDR, wgrant=onehot(winner), waddr=winner (1-cycle grant latency).
REQ-008 ADDR: wgrant held; on aw_hs -> RESP; aw_req changes of the granted requester shall not alter grant.
REQ-009 RESP: on b_hs -> HOLD if aw_lock[waddr]=1, else IDLE with wgrant=0 next cycle and rr pointer = (waddr+1) mod NUM.
REQ-010 HOLD (locked sequence): wgrant held; aw_req[waddr]=1 -> ADDR; else aw_lock[waddr]=0 -> IDLE with pointer update as REQ-009; other requesters shall never win while in HOLD.
REQ-011 aw_hs and b_hs in the same cycle during ADDR: b_hs ignored, go RESP; b_hs in IDLE/ADDR/HOLD ignored; aw_hs in IDLE/RESP/HOLD ignored.
REQ-012 Timeout counter: cleared on RESP entry, increments each RESP cycle without b_hs; when count reaches TIMEOUT-1 without b_hs, wtimeout=1 for one cycle and state -> IDLE, grant released, pointer updated, lock discarded.
REQ-013 TIMEOUT=0: counter inactive, wtimeout constant 0.
REQ-014 waddr shall hold the last granted index in IDLE (datapath select stable); wgrant=0 in IDLE.
REQ-015 rr pointer width NSIZE, wraps NUM-1 -> 0; indices >= NUM never granted.
REQ-016 All outputs registered; no combinational path input -> output.

Reset
REQ-017 rst_n=0 asynchronously: state IDLE, wgrant/rgrant=0, waddr/raddr=0, wbusy/rbusy=0, wtimeout/rtimeout=0, rr pointers=0, counters=0.
REQ-018 Reset asserted mid-transaction shall abort it without pulse; after release, arbitration restarts from pointer 0.

Verification
REQ-019 NUM=4, aw_req=4'b1010 held, each txn completes -> grants 1,3,1,3; wgrant one cycle after request, drop one cycle after b_hs.
REQ-020 Req 0 granted with aw_lock[0]=1, aw_req=4'b1111 -> requester 0 retains grant across two txns; lock falls, no req -> IDLE, next grant = 1.
REQ-021 TIMEOUT=8, aw_hs then no b_hs -> wtimeout pulse exactly 8 cycles after RESP entry, wbusy=0 next cycle.
REQ-022 Concurrent ar_req=4'b0100, aw_req=4'b0001 -> rgrant=4'b0100 and wgrant=4'b0001 simultaneously, independent completion.
REQ-023 rst_n low during RESP -> all outputs 0 immediately, no timeout pulse; after release aw_req=4'b1000 -> grant 3.
REQ-024 aw_hs and b_hs same cycle in ADDR -> state RESP, grant held until next b_hs.
